// File: rtl/fetch_predict_unit.sv
// Fetch-stage PC owner with a direct-mapped BTB and 2-bit saturating counters.
// Optional hit/redirect counters are built when FETCH_STATS_EN is defined.
module fetch_predict_unit #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned BTB_ENTRIES = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_f,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              update_valid,
   input  logic [ADDR_W-1:0] update_pc,
   input  logic [ADDR_W-1:0] update_target,
   input  logic              update_taken,
   input  logic              update_is_jump,
   output logic [ADDR_W-1:0] pc_f,
   output logic [ADDR_W-1:0] pc_plus4_f,
   output logic              pred_taken_f,
   output logic [ADDR_W-1:0] pred_target_f,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_redirects
);

   localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
   localparam int unsigned TagW = ADDR_W - IdxW - 2;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q  [BTB_ENTRIES];
   logic [TagW-1:0]   tag_q    [BTB_ENTRIES];
   logic [ADDR_W-1:0] target_q [BTB_ENTRIES];
   logic [1:0]        ctr_q    [BTB_ENTRIES];

   logic [IdxW-1:0] look_idx, upd_idx;
   logic [TagW-1:0] look_tag, upd_tag;
   logic            look_hit, upd_hit;
   logic            wr_en, wr_tgt_en;
   logic [1:0]      wr_ctr;

   assign look_idx = pc_q[IdxW+1:2];
   assign look_tag = pc_q[ADDR_W-1:IdxW+2];
   assign upd_idx  = update_pc[IdxW+1:2];
   assign upd_tag  = update_pc[ADDR_W-1:IdxW+2];
   assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
   assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   assign pc_f          = pc_q;
   assign pc_plus4_f    = pc_q + ADDR_W'(4);
   assign pred_taken_f  = look_hit && ctr_q[look_idx][1];
   assign pred_target_f = look_hit ? target_q[look_idx] : '0;

   always_comb begin
      pc_d = pc_plus4_f;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (stall_f) begin
         pc_d = pc_q;
      end else if (pred_taken_f) begin
         pc_d = pred_target_f;
      end
   end

   // Misses only allocate on a taken outcome; tag/valid rewrites on a hit are idempotent.
   always_comb begin
      wr_en     = update_valid && (upd_hit || update_taken || update_is_jump);
      wr_tgt_en = wr_en && (update_taken || update_is_jump);
      wr_ctr    = ctr_q[upd_idx];
      if (update_is_jump) begin
         wr_ctr = 2'd3;
      end else if (!upd_hit) begin
         wr_ctr = 2'd2;
      end else if (update_taken) begin
         wr_ctr = (ctr_q[upd_idx] == 2'd3) ? 2'd3 : ctr_q[upd_idx] + 2'd1;
      end else begin
         wr_ctr = (ctr_q[upd_idx] == 2'd0) ? 2'd0 : ctr_q[upd_idx] - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'd0;
         end
      end else begin
         pc_q <= pc_d;
         if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            ctr_q[upd_idx]   <= wr_ctr;
         end
         if (wr_tgt_en) begin
            target_q[upd_idx] <= update_target;
         end
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] hits_q, hits_d, redirs_q, redirs_d;

   always_comb begin
      hits_d   = hits_q;
      redirs_d = redirs_q;
      if (!stall_f && look_hit && (hits_q != 32'hFFFF_FFFF)) begin
         hits_d = hits_q + 32'd1;
      end
      if (redirect_valid && (redirs_q != 32'hFFFF_FFFF)) begin
         redirs_d = redirs_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hits_q   <= '0;
         redirs_q <= '0;
      end else begin
         hits_q   <= hits_d;
         redirs_q <= redirs_d;
      end
   end

   assign stat_hits      = hits_q;
   assign stat_redirects = redirs_q;
`else
   assign stat_hits      = '0;
   assign stat_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench: each step queues the expected fetch outputs; a negedge monitor checks them.
module tb_fetch_predict_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_f = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        update_valid = 1'b0;
   logic [31:0] update_pc = '0;
   logic [31:0] update_target = '0;
   logic        update_taken = 1'b0;
   logic        update_is_jump = 1'b0;
   logic [31:0] pc_f, pc_plus4_f, pred_target_f, stat_hits, stat_redirects;
   logic        pred_taken_f;

   fetch_predict_unit #(
      .ADDR_W(32),
      .BTB_ENTRIES(16),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall_f(stall_f),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .update_valid(update_valid),
      .update_pc(update_pc),
      .update_target(update_target),
      .update_taken(update_taken),
      .update_is_jump(update_is_jump),
      .pc_f(pc_f),
      .pc_plus4_f(pc_plus4_f),
      .pred_taken_f(pred_taken_f),
      .pred_target_f(pred_target_f),
      .stat_hits(stat_hits),
      .stat_redirects(stat_redirects)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          step;
      logic [31:0] pc;
      logic [31:0] plus4;
      logic        pt;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   step_no = 0;
   int   exp_hits = 0;
   int   exp_redirs = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: the fetch outputs are presented every cycle once the queue holds an entry.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check32($sformatf("pc_f step%0d", e.step), pc_f, e.pc);
         check32($sformatf("pc_plus4_f step%0d", e.step), pc_plus4_f, e.plus4);
         check32($sformatf("pred_taken_f step%0d", e.step), {31'b0, pred_taken_f}, {31'b0, e.pt});
         check32($sformatf("pred_target_f step%0d", e.step), pred_target_f, e.tgt);
      end
   end

   task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic ut, input logic uj,
                       input logic [31:0] epc, input logic ept, input logic [31:0] etgt,
                       input logic ehit);
      exp_t e;
      stall_f        = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      update_valid   = uv;
      update_pc      = upc;
      update_target  = utgt;
      update_taken   = ut;
      update_is_jump = uj;
      e.step  = step_no;
      e.pc    = epc;
      e.plus4 = epc + 32'd4;
      e.pt    = ept;
      e.tgt   = etgt;
      exp_q.push_back(e);
      if (ehit && !st) exp_hits++;
      if (rd) exp_redirs++;
      step_no++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, step %0d of 26", step_no);
      $fatal(1, "timeout");
   end

   initial begin
      #3;
      check32("reset pc_f", pc_f, 32'h0);
      check32("reset pc_plus4_f", pc_plus4_f, 32'h4);
      check32("reset pred_taken_f", {31'b0, pred_taken_f}, 32'h0);
      check32("reset pred_target_f", pred_target_f, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      //   st rd rpc            uv upc       utgt      ut uj  exp_pc          pt tgt       hit
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h00,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h04,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h08,         0, 32'h0,    0);
      step(0, 0, 32'h0,         1, 32'h10,   32'h40,   1, 0,  32'h0C,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h10,         1, 32'h40,   1);
      step(0, 1, 32'h10,        1, 32'h10,   32'h99,   0, 0,  32'h40,         0, 32'h0,    0);
      step(1, 0, 32'h0,         1, 32'h10,   32'h99,   0, 0,  32'h10,         0, 32'h40,   1);
      step(0, 0, 32'h0,         1, 32'h10,   32'h99,   0, 0,  32'h10,         0, 32'h40,   1);
      step(0, 0, 32'h0,         1, 32'h10,   32'h40,   1, 0,  32'h14,         0, 32'h0,    0);
      step(0, 1, 32'h10,        0, 32'h0,    32'h0,    0, 0,  32'h18,         0, 32'h0,    0);
      step(1, 1, 32'h80,        0, 32'h0,    32'h0,    0, 0,  32'h10,         0, 32'h40,   1);
      step(1, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h80,         0, 32'h0,    0);
      step(1, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h80,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h80,         0, 32'h0,    0);
      step(0, 1, 32'h10,        1, 32'h10,   32'h44,   0, 1,  32'h84,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h10,         1, 32'h44,   1);
      step(0, 1, 32'h10,        1, 32'h50,   32'h60,   1, 0,  32'h44,         0, 32'h0,    0);
      step(0, 1, 32'h50,        0, 32'h0,    32'h0,    0, 0,  32'h10,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h50,         1, 32'h60,   1);
      step(0, 1, 32'h50,        1, 32'h50,   32'h70,   1, 0,  32'h60,         0, 32'h0,    0);
      step(0, 0, 32'h0,         1, 32'h90,   32'h99,   0, 0,  32'h50,         1, 32'h70,   1);
      step(0, 1, 32'h50,        0, 32'h0,    32'h0,    0, 0,  32'h70,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h50,         1, 32'h70,   1);
      step(0, 1, 32'hFFFFFFFC,  0, 32'h0,    32'h0,    0, 0,  32'h70,         0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'hFFFFFFFC,   0, 32'h0,    0);
      step(0, 0, 32'h0,         0, 32'h0,    32'h0,    0, 0,  32'h00,         0, 32'h0,    0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      check32("scoreboard drained", exp_q.size(), 32'd0);
`ifdef FETCH_STATS_EN
      check32("stat_hits", stat_hits, exp_hits);
      check32("stat_redirects", stat_redirects, exp_redirs);
`else
      check32("stat_hits (disabled)", stat_hits, 32'd0);
      check32("stat_redirects (disabled)", stat_redirects, 32'd0);
`endif

      // Asynchronous reset mid-cycle while redirect and stall are both asserted.
      @(posedge clk);
      #2;
      stall_f        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h50;
      rst            = 1'b1;
      #1;
      check32("async reset pc_f", pc_f, 32'h0);
      check32("async reset stat_hits", stat_hits, 32'd0);
      check32("async reset stat_redirects", stat_redirects, 32'd0);
      @(posedge clk);
      #1;
      check32("reset held pc_f", pc_f, 32'h0);
      rst = 1'b0;
      stall_f = 1'b0;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      check32("post-reset redirect pc_f", pc_f, 32'h50);
      check32("post-reset BTB cleared", {31'b0, pred_taken_f}, 32'h0);
      check32("post-reset target zero", pred_target_f, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
